// File: rtl/sm_pkg.sv
// Shared types and constants for the sign-magnitude sort controller.
// Words are sign-magnitude: MSB is the sign (1 = negative), the rest is magnitude.
package sm_pkg;

   typedef enum logic [1:0] {LOAD, SORT, DRAIN} sort_state_t;

   localparam int SM_W = 8;
   localparam logic [SM_W-1:0] SM_POS_ZERO = 8'h00;
   localparam logic [SM_W-1:0] SM_NEG_ZERO = 8'h80;

   function automatic logic sm_neg(input logic [SM_W-1:0] x);
      return x[SM_W-1];
   endfunction

endpackage

// File: rtl/comparator.sv
// Sign-magnitude "greater or equal": o_out = (i_a >= i_b).
// -0 orders strictly before +0, so mixed-sign inputs are decided by sign alone.
module comparator #(
   parameter int N = 8
) (
   input  logic [N-1:0] i_a,
   input  logic [N-1:0] i_b,
   output logic         o_out
);

   logic a_neg;
   logic b_neg;
   logic [N-2:0] a_mag;
   logic [N-2:0] b_mag;

   assign a_neg = i_a[N-1];
   assign b_neg = i_b[N-1];
   assign a_mag = i_a[N-2:0];
   assign b_mag = i_b[N-2:0];

   // Among negatives a larger magnitude is a smaller value.
   always_comb begin
      o_out = 1'b0;
      if (a_neg != b_neg)
         o_out = !a_neg;
      else if (!a_neg)
         o_out = (a_mag >= b_mag);
      else
         o_out = (a_mag <= b_mag);
   end

endmodule

// File: rtl/sm_sort_ctrl.sv
// Batch buffer that loads DEPTH sign-magnitude words, bubble-sorts them in place
// with one shared comparator (one compare per cycle) and streams them out ascending.
module sm_sort_ctrl
   import sm_pkg::*;
#(
   parameter int N     = 8,
   parameter int DEPTH = 8
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_valid,
   input  logic [N-1:0] i_data,
   output logic         o_ready,
   output logic         o_valid,
   output logic [N-1:0] o_data,
   input  logic         i_ready,
   output logic         o_busy,
   output logic         o_done
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam int IW = $clog2(DEPTH);
   localparam logic [CW-1:0] LAST_IDX  = CW'(DEPTH - 1);
   localparam logic [CW-1:0] LAST_PASS = CW'(DEPTH - 2);

   sort_state_t state;
   logic [N-1:0]  mem [DEPTH];
   logic [CW-1:0] wr_cnt;
   logic [CW-1:0] rd_cnt;
   logic [CW-1:0] j;
   logic [CW-1:0] p;
   logic          swap_flag;

   logic [IW-1:0] j_idx;
   logic [IW-1:0] j1_idx;
   logic          ge;
   logic          last_j;
   logic          swapped_now;

   assign j_idx       = j[IW-1:0];
   assign j1_idx      = j_idx + IW'(1);
   assign last_j      = (j == LAST_PASS - p);
   assign swapped_now = swap_flag | !ge;
   assign o_data      = mem[rd_cnt[IW-1:0]];

   comparator #(.N(N)) u_cmp (
      .i_a   (mem[j1_idx]),
      .i_b   (mem[j_idx]),
      .o_out (ge)
   );

   // Swapping only on a strict "less than" keeps equal words in arrival order.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state     <= LOAD;
         wr_cnt    <= '0;
         rd_cnt    <= '0;
         j         <= '0;
         p         <= '0;
         swap_flag <= 1'b0;
         o_ready   <= 1'b1;
         o_valid   <= 1'b0;
         o_busy    <= 1'b0;
         o_done    <= 1'b0;
      end else begin
         o_done <= 1'b0;
         case (state)
            LOAD: begin
               if (i_valid && o_ready) begin
                  mem[wr_cnt[IW-1:0]] <= i_data;
                  if (wr_cnt == LAST_IDX) begin
                     state     <= SORT;
                     wr_cnt    <= '0;
                     j         <= '0;
                     p         <= '0;
                     swap_flag <= 1'b0;
                     o_ready   <= 1'b0;
                     o_busy    <= 1'b1;
                  end else begin
                     wr_cnt <= wr_cnt + CW'(1);
                  end
               end
            end
            SORT: begin
               if (!ge) begin
                  mem[j_idx]  <= mem[j1_idx];
                  mem[j1_idx] <= mem[j_idx];
               end
               if (last_j) begin
                  if (!swapped_now || p == LAST_PASS) begin
                     state   <= DRAIN;
                     rd_cnt  <= '0;
                     o_busy  <= 1'b0;
                     o_valid <= 1'b1;
                  end else begin
                     p         <= p + CW'(1);
                     j         <= '0;
                     swap_flag <= 1'b0;
                  end
               end else begin
                  j         <= j + CW'(1);
                  swap_flag <= swapped_now;
               end
            end
            DRAIN: begin
               if (o_valid && i_ready) begin
                  if (rd_cnt == LAST_IDX) begin
                     state   <= LOAD;
                     rd_cnt  <= '0;
                     o_valid <= 1'b0;
                     o_ready <= 1'b1;
                     o_done  <= 1'b1;
                  end else begin
                     rd_cnt <= rd_cnt + CW'(1);
                  end
               end
            end
            default: begin
               state   <= LOAD;
               o_ready <= 1'b1;
               o_valid <= 1'b0;
               o_busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sm_sort_ctrl.sv
// Directed bench for sm_sort_ctrl (N=8, DEPTH=8) with hand-computed sorted outputs.
module tb_sm_sort_ctrl;

   typedef logic [7:0] vec_t [8];

   logic       i_clk;
   logic       i_rst;
   logic       i_valid;
   logic [7:0] i_data;
   logic       o_ready;
   logic       o_valid;
   logic [7:0] o_data;
   logic       i_ready;
   logic       o_busy;
   logic       o_done;

   int tests_run = 0;
   int tests_failed = 0;
   int busy_cycles;

   sm_sort_ctrl #(.N(8), .DEPTH(8)) dut (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_valid (i_valid),
      .i_data  (i_data),
      .o_ready (o_ready),
      .o_valid (o_valid),
      .o_data  (o_data),
      .i_ready (i_ready),
      .o_busy  (o_busy),
      .o_done  (o_done)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   // Loads one batch; with gap set, every other word is preceded by an idle cycle.
   task automatic applyStimulus(input vec_t w, input bit gap);
      for (int k = 0; k < 8; k++) begin
         if (gap && (k % 2 == 1)) begin
            i_valid = 1'b0;
            i_data  = 8'hxx;
            tick();
         end
         i_valid = 1'b1;
         i_data  = w[k];
         tick();
      end
      i_valid = 1'b0;
   endtask

   task automatic waitSort(output int busy);
      busy = 0;
      if (o_busy) begin
         checkOutput("sort_ready_low", {31'd0, o_ready}, 32'd0);
         checkOutput("sort_valid_low", {31'd0, o_valid}, 32'd0);
      end
      while (o_busy && busy < 200) begin
         busy++;
         tick();
      end
      if (busy >= 200) checkOutput("sort_timeout", 32'd0, 32'd1);
   endtask

   task automatic drainAndCheck(input vec_t e, input bit stall);
      for (int k = 0; k < 8; k++) begin
         int g = 0;
         while (!o_valid && g < 50) begin
            g++;
            tick();
         end
         if (!o_valid) checkOutput("valid_timeout", 32'd0, 32'd1);
         checkOutput($sformatf("data[%0d]", k), {24'd0, o_data}, {24'd0, e[k]});
         if (stall && (k % 2 == 0)) begin
            i_ready = 1'b0;
            tick();
            checkOutput($sformatf("hold1[%0d]", k), {24'd0, o_data}, {24'd0, e[k]});
            tick();
            checkOutput($sformatf("hold2[%0d]", k), {24'd0, o_data}, {24'd0, e[k]});
         end
         checkOutput("done_early", {31'd0, o_done}, 32'd0);
         i_ready = 1'b1;
         tick();
         i_ready = 1'b0;
      end
      checkOutput("done_pulse", {31'd0, o_done}, 32'd1);
      checkOutput("ready_after", {31'd0, o_ready}, 32'd1);
      checkOutput("valid_after", {31'd0, o_valid}, 32'd0);
      tick();
      checkOutput("done_low", {31'd0, o_done}, 32'd0);
   endtask

   vec_t in1  = '{8'h03, 8'h85, 8'h00, 8'h80, 8'h07, 8'h87, 8'h01, 8'h02};
   vec_t out1 = '{8'h87, 8'h85, 8'h80, 8'h00, 8'h01, 8'h02, 8'h03, 8'h07};
   vec_t in2  = '{8'h81, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
   vec_t in3  = '{8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01, 8'h00};
   vec_t out3 = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
   vec_t in6  = '{8'h05, 8'h85, 8'h05, 8'h85, 8'h05, 8'h85, 8'h05, 8'h85};
   vec_t out6 = '{8'h85, 8'h85, 8'h85, 8'h85, 8'h05, 8'h05, 8'h05, 8'h05};

   initial begin
      i_rst   = 1'b1;
      i_valid = 1'b0;
      i_data  = 8'h00;
      i_ready = 1'b0;
      tick();
      tick();
      checkOutput("rst_ready", {31'd0, o_ready}, 32'd1);
      checkOutput("rst_valid", {31'd0, o_valid}, 32'd0);
      checkOutput("rst_busy",  {31'd0, o_busy},  32'd0);
      checkOutput("rst_done",  {31'd0, o_done},  32'd0);
      i_rst = 1'b0;
      tick();

      // Mixed signs including both zeros
      applyStimulus(in1, 1'b0);
      checkOutput("t1_busy_start", {31'd0, o_busy}, 32'd1);
      waitSort(busy_cycles);
      drainAndCheck(out1, 1'b0);

      // Already sorted: one pass only
      applyStimulus(in2, 1'b0);
      waitSort(busy_cycles);
      checkOutput("t2_busy_cycles", busy_cycles, 32'd7);
      drainAndCheck(in2, 1'b0);

      // Reverse order: worst case
      applyStimulus(in3, 1'b0);
      waitSort(busy_cycles);
      checkOutput("t3_busy_cycles", busy_cycles, 32'd28);
      drainAndCheck(out3, 1'b0);

      // Gapped load and stalled drain
      applyStimulus(in1, 1'b1);
      waitSort(busy_cycles);
      drainAndCheck(out1, 1'b1);

      // Reset in the middle of sorting, then a fresh batch
      applyStimulus(in3, 1'b0);
      tick();
      tick();
      checkOutput("t5_busy_before", {31'd0, o_busy}, 32'd1);
      i_rst = 1'b1;
      tick();
      i_rst = 1'b0;
      checkOutput("t5_ready", {31'd0, o_ready}, 32'd1);
      checkOutput("t5_busy",  {31'd0, o_busy},  32'd0);
      checkOutput("t5_valid", {31'd0, o_valid}, 32'd0);
      applyStimulus(in1, 1'b0);
      waitSort(busy_cycles);
      drainAndCheck(out1, 1'b0);

      // Duplicates
      applyStimulus(in6, 1'b0);
      waitSort(busy_cycles);
      drainAndCheck(out6, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
